prenc_iter: RTL and testbench



---
 rtl/prenc_pkg.sv | 31 +++
 rtl/prenc_msb.sv | 24 ++
 rtl/prenc_iter.sv | 98 +++++++++
 tb/tb_prenc_iter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/prenc_pkg.sv
// Shared types and helpers for the iterative priority encoder (prenc_iter).
package prenc_pkg;

  // Upper bound on request vector width supported by the helper functions.
  localparam int MAX_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } prenc_state_e;

  function automatic int popcount(input logic [MAX_W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Index of the highest set bit, or -1 when no bit is set.
  function automatic int lead_one(input logic [MAX_W-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/prenc_msb.sv
// Combinational MSB-first priority encoder with hit flag; idx is 0 when no bit is set.
module prenc_msb
  import prenc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  logic [MAX_W-1:0] vec_ext;
  int               lo;

  always_comb begin
    vec_ext = '0;
    vec_ext[WIDTH-1:0] = vec;
    lo  = lead_one(vec_ext);
    hit = (lo >= 0);
    idx = hit ? IDX_W'(lo) : '0;
  end

endmodule

// File: rtl/prenc_iter.sv
// Sequential priority encoder: emits the index of every set bit of a captured vector, MSB first.
// Optional macro PRENC_COUNT_EN adds hit_cnt, the popcount of the captured vector.
module prenc_iter
  import prenc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
`ifdef PRENC_COUNT_EN
  output logic [IDX_W:0]   hit_cnt,
`endif
  output logic             busy
);

  // Handshakes: a transfer happens on a channel only in a cycle where both
  // valid and ready are high at the rising clock edge; in_ready may depend
  // combinationally on out_ready so a new vector can load on the last beat.

  prenc_state_e     state;
  logic [WIDTH-1:0] pend;
  logic             zflag;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_hit;
  logic [MAX_W-1:0] pend_ext;
  int               pend_cnt;
  logic             accept;
  logic             fire;

  prenc_msb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_msb (
    .vec (pend),
    .idx (enc_idx),
    .hit (enc_hit)
  );

  always_comb begin
    pend_ext = '0;
    pend_ext[WIDTH-1:0] = pend;
    pend_cnt = popcount(pend_ext);
  end

  assign busy      = (state == EMIT);
  assign out_valid = busy;
  assign out_idx   = (busy && enc_hit) ? enc_idx : '0;
  assign out_last  = busy && (pend_cnt <= 1);
  assign out_zero  = busy && zflag;

  assign fire     = out_valid && out_ready;
  assign in_ready = (state == IDLE) || (fire && out_last);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      zflag <= 1'b0;
    end else if (accept) begin
      // A reload on the final beat takes precedence over returning to IDLE.
      state <= EMIT;
      pend  <= in_vec;
      zflag <= (in_vec == '0);
    end else if (fire) begin
      pend <= pend & ~(WIDTH'(1) << out_idx);
      if (out_last) begin
        state <= IDLE;
        zflag <= 1'b0;
      end
    end
  end

`ifdef PRENC_COUNT_EN
  logic [MAX_W-1:0] in_ext;

  always_comb begin
    in_ext = '0;
    in_ext[WIDTH-1:0] = in_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (accept) begin
      hit_cnt <= (IDX_W+1)'(popcount(in_ext));
    end
  end
`endif

endmodule

// File: tb/tb_prenc_iter.sv
// Directed bench for prenc_iter (WIDTH=8); exercises handshake, backpressure, zero vectors and async reset.
module tb_prenc_iter;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;
  logic             busy;
`ifdef PRENC_COUNT_EN
  logic [IDX_W:0]   hit_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  prenc_iter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero),
`ifdef PRENC_COUNT_EN
    .hit_cnt   (hit_cnt),
`endif
    .busy      (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic last, input logic zero);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"},   32'(out_idx),   32'(idx));
    chk({tag, "_last"},  32'(out_last),  32'(last));
    chk({tag, "_zero"},  32'(out_zero),  32'(zero));
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_busy"},  32'(busy),      32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
  endtask

  // Driver: advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'hFF;
    out_ready = 1'b1;

    // Reset held with in_valid high
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_idx",   32'(out_idx),   32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_zero",  32'(out_zero),  32'd0);
`ifdef PRENC_COUNT_EN
    chk("rst_cnt",   32'(hit_cnt),   32'd0);
`endif
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk_idle("post_rst");

    // 0000_0101: idx 2 then idx 0 (last)
    send(8'b0000_0101);
    chk_beat("v05_b0", 2, 1'b0, 1'b0);
    chk("v05_b0_inrdy", 32'(in_ready), 32'd0);
`ifdef PRENC_COUNT_EN
    chk("v05_b0_cnt", 32'(hit_cnt), 32'd2);
`endif
    tick();
    chk_beat("v05_b1", 0, 1'b1, 1'b0);
    chk("v05_b1_inrdy", 32'(in_ready), 32'd1);
`ifdef PRENC_COUNT_EN
    chk("v05_b1_cnt", 32'(hit_cnt), 32'd2);
`endif
    tick();
    chk_idle("v05_end");

    // Zero vector: one beat, out_zero set
    send(8'h00);
    chk_beat("v00", 0, 1'b1, 1'b1);
`ifdef PRENC_COUNT_EN
    chk("v00_cnt", 32'(hit_cnt), 32'd0);
`endif
    tick();
    chk_idle("v00_end");

    // Backpressure on 0xA0
    out_ready = 1'b0;
    send(8'hA0);
    for (int i = 0; i < 3; i++) begin
      chk_beat("va0_hold", 7, 1'b0, 1'b0);
      chk("va0_hold_inrdy", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk_beat("va0_b0", 7, 1'b0, 1'b0);
    tick();
    chk_beat("va0_b1", 5, 1'b1, 1'b0);
    tick();
    chk_idle("va0_end");

    // Back-to-back: 0x80 offered on last beat of 0x01
    send(8'h01);
    chk_beat("b2b_a", 0, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_vec   = 8'h80;
    #1;
    chk("b2b_inrdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    chk_beat("b2b_b", 7, 1'b1, 1'b0);
`ifdef PRENC_COUNT_EN
    chk("b2b_cnt", 32'(hit_cnt), 32'd1);
`endif
    tick();
    chk_idle("b2b_end");

    // All-ones: WIDTH beats, descending index
    send(8'hFF);
    for (int i = 7; i >= 0; i--) begin
      chk_beat("vff", i, (i == 0), 1'b0);
`ifdef PRENC_COUNT_EN
      chk("vff_cnt", 32'(hit_cnt), 32'd8);
`endif
      tick();
    end
    chk_idle("vff_end");

    // Async reset after two beats of 0xFF
    send(8'hFF);
    chk_beat("rst_mid_b0", 7, 1'b0, 1'b0);
    tick();
    chk_beat("rst_mid_b1", 6, 1'b0, 1'b0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy",  32'(busy),      32'd0);
    chk("rst_mid_ready", 32'(in_ready),  32'd1);
    chk("rst_mid_idx",   32'(out_idx),   32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk_idle("rst_mid_after");
    send(8'h02);
    chk_beat("rst_mid_v02", 1, 1'b1, 1'b0);
    tick();
    chk_idle("rst_mid_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
